// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor:
// FSM state encoding plus operation and mode selector values.
package serial_addsub_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic OP_ADD   = 1'b0;
   localparam logic OP_SUB   = 1'b1;
   localparam logic SIGNED   = 1'b1;
   localparam logic UNSIGNED = 1'b0;

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational K-bit ripple adder used once per digit.
// Ports: a, b (K), cin -> s (K), cout.
module serial_addsub_digit_adder #(
   parameter int K = 2
) (
   input  logic [K-1:0] a,
   input  logic [K-1:0] b,
   input  logic         cin,
   output logic [K-1:0] s,
   output logic         cout
);

   always_comb begin
      {cout, s} = {1'b0, a} + {1'b0, b} + {{K{1'b0}}, cin};
   end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial N-bit adder/subtractor, K bits per clock.
// Ports: clk, rst (sync, high), start, a, b, sub, symbol in;
//  busy, done, sum, cout, overflow out.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int N = 8,
   parameter int K = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   input  logic         symbol,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         overflow
);

   localparam int DIGITS = N / K;
   // One spare bit so the count never wraps at a power of two.
   localparam int CW = $clog2(DIGITS) + 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   a_sh;
   logic [N-1:0]   b_sh;
   logic [N-1:0]   res_sh;
   logic [N-1:0]   res_next;
   logic [N-1:0]   s_ext;
   logic           carry;
   logic           sym;
   logic [CW-1:0]  cnt;
   logic [K-1:0]   dig_s;
   logic           dig_c;
   logic           last;
   logic           accept;
   logic           ovf_next;

   serial_addsub_digit_adder #(.K(K)) u_digit (
      .a    (a_sh[K-1:0]),
      .b    (b_sh[K-1:0]),
      .cin  (carry),
      .s    (dig_s),
      .cout (dig_c)
   );

   assign busy = (state == ST_RUN);
   assign last = (state == ST_RUN) && (cnt == LAST);

   // New digit enters at the top; after the last digit the
   // register holds the whole result in order.
   always_comb begin
      s_ext = '0;
      s_ext[K-1:0] = dig_s;
      res_next = (res_sh >> K) | (s_ext << (N - K));
   end

   // On the last digit the operand low bits are the MSBs of A and b_eff.
   always_comb begin
      ovf_next = sym
         && (a_sh[K-1] == b_sh[K-1])
         && (res_next[N-1] != a_sh[K-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         carry    <= 1'b0;
         sym      <= 1'b0;
         cnt      <= '0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_sh   <= a;
            b_sh   <= (sub == OP_SUB) ? ~b : b;
            carry  <= sub;
            sym    <= symbol;
            cnt    <= '0;
            res_sh <= '0;
         end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> K;
            b_sh   <= b_sh >> K;
            res_sh <= res_next;
            carry  <= dig_c;
            cnt    <= cnt + CW'(1);
            if (last) begin
               sum      <= res_next;
               cout     <= dig_c;
               overflow <= ovf_next;
               done     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (N=8 with K=2 and K=8).
// Ports: none; drives both DUT instances and prints a summary.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       sub = 1'b0;
   logic       symbol = 1'b0;
   logic       busy, done, cout, overflow;
   logic [7:0] sum;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] sum8;

   int checks = 0;
   int errors = 0;
   int lat;
   int pulses;
   logic [7:0] got_sum;

   always #5 clk = ~clk;

   serial_addsub #(.N(8), .K(2)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a(a), .b(b), .sub(sub), .symbol(symbol),
      .busy(busy), .done(done), .sum(sum),
      .cout(cout), .overflow(overflow)
   );

   serial_addsub #(.N(8), .K(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8),
      .a(a), .b(b), .sub(sub), .symbol(symbol),
      .busy(busy8), .done(done8), .sum(sum8),
      .cout(cout8), .overflow(ovf8)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic logic [9:0] model(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic s,
                                        input logic sy);
      int ua, ub, ur, sa, sb, sr;
      logic c, v;
      ua = int'(x);
      ub = int'(y);
      sa = int'($signed(x));
      sb = int'($signed(y));
      if (s) begin
         ur = ua - ub;
         c  = (ua >= ub);
         sr = sa - sb;
      end else begin
         ur = ua + ub;
         c  = (ur > 255);
         sr = sa + sb;
      end
      v = sy && ((sr > 127) || (sr < -128));
      return {v, c, ur[7:0]};
   endfunction

   task automatic do_op(input logic [7:0] ta,
                        input logic [7:0] tb_v,
                        input logic ts,
                        input logic tsym,
                        input logic [9:0] exp,
                        input string tag);
      @(negedge clk);
      a = ta; b = tb_v; sub = ts; symbol = tsym;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, ".busy"}, 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 20) begin
         @(posedge clk);
         #1 lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'd4);
      check({tag, ".sum"}, 32'(sum), 32'(exp[7:0]));
      check({tag, ".cout"}, 32'(cout), 32'(exp[8]));
      check({tag, ".ovf"}, 32'(overflow), 32'(exp[9]));
      check({tag, ".busy0"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic rs, rsy;

      repeat (3) @(posedge clk);
      #1;
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.sum", 32'(sum), 32'd0);
      check("rst.cout", 32'(cout), 32'd0);
      check("rst.ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      do_op(8'd200, 8'd100, 1'b0, 1'b0, {1'b0, 1'b1, 8'd44}, "uadd");
      do_op(8'd100, 8'd50, 1'b0, 1'b1, {1'b1, 1'b0, 8'h96}, "sadd");
      do_op(8'h80, 8'h01, 1'b1, 1'b1, {1'b1, 1'b1, 8'h7F}, "ssub");
      do_op(8'd5, 8'd7, 1'b1, 1'b0, {1'b0, 1'b0, 8'hFE}, "usub");

      for (int i = 0; i < 40; i++) begin
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         rs  = 1'($urandom);
         rsy = 1'($urandom);
         do_op(ra, rb, rs, rsy, model(ra, rb, rs, rsy), "rand");
      end

      // Start during RUN must be ignored.
      @(negedge clk);
      a = 8'h10; b = 8'h20; sub = 1'b0; symbol = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      got_sum = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            pulses++;
            got_sum = sum;
         end
      end
      check("ign.pulses", 32'(pulses), 32'd1);
      check("ign.sum", 32'(got_sum), 32'h30);

      // Reset in the middle of RUN aborts the operation.
      @(negedge clk);
      a = 8'd3; b = 8'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.sum", 32'(sum), 32'd0);
      check("abort.cout", 32'(cout), 32'd0);
      check("abort.ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         if (done) pulses++;
      end
      check("abort.nodone", 32'(pulses), 32'd0);
      do_op(8'd3, 8'd4, 1'b0, 1'b0, model(8'd3, 8'd4, 1'b0, 1'b0),
            "after");

      // Single-cycle configuration.
      @(negedge clk);
      a = 8'd127; b = 8'd1; sub = 1'b0; symbol = 1'b1;
      start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      check("k8.busy", 32'(busy8), 32'd1);
      check("k8.early", 32'(done8), 32'd0);
      @(posedge clk);
      #1;
      check("k8.done", 32'(done8), 32'd1);
      check("k8.sum", 32'(sum8), 32'h80);
      check("k8.cout", 32'(cout8), 32'd0);
      check("k8.ovf", 32'(ovf8), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
